bcd_serial_adder: RTL

//  Multi-digit BCD add/subtract unit, digit-serial: one BCD digit per clock, LSD first.

---
 rtl/bcd_serial_adder_if.sv | 42 ++++
 rtl/bcd_serial_adder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder_if.sv
// Request/response bundle for bcd_serial_adder (valid/ready on both sides).
// The err signal exists only when BCD_CHECK_EN is defined.
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
) ();
    localparam int W = 4 * DIGITS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         busy;
`ifdef BCD_CHECK_EN
    logic         err;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, busy, err
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, busy, err
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, busy
    );
`endif
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD add/subtract unit, one digit per clock, least significant digit first.
// Optional input digit checking (err output) is enabled by defining BCD_CHECK_EN.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    bcd_serial_adder_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  s_q;
    logic          sub_q;
    logic          carry;
    logic [IW-1:0] idx;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          cout_q;
    logic          busy_q;

    logic [3:0]    b_eff;
    logic [4:0]    t_raw;
    logic [4:0]    t_adj;
    logic [W-1:0]  s_next;

    // Operands shift right each RUN cycle so the current digit is always in the low nibble;
    // the result digit enters at the top and reaches its own position after DIGITS shifts.
    always_comb begin
        b_eff  = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
        t_raw  = {1'b0, a_q[3:0]} + {1'b0, b_eff} + {4'b0000, carry};
        t_adj  = (t_raw > 5'd9) ? (t_raw + 5'd6) : t_raw;
        s_next = (s_q >> 4) | (W'(t_adj[3:0]) << (W - 4));
    end

`ifdef BCD_CHECK_EN
    logic err_q;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic [W-1:0] tmp;
        logic         bad;
        tmp = v;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (tmp[3:0] > 4'd9) begin
                bad = 1'b1;
            end
            tmp = tmp >> 4;
        end
        return bad;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && bus.in_valid && in_ready_q) begin
            err_q <= has_bad_digit(bus.a) | has_bad_digit(bus.b);
        end
    end

    assign bus.err = err_q;
`endif

    // RUN holds one extra cycle after the last digit so the final carry lands in cout on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            sub_q       <= 1'b0;
            carry       <= 1'b0;
            idx         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        sub_q      <= bus.sub;
                        carry      <= bus.sub ? 1'b1 : bus.cin;
                        idx        <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (idx == IW'(DIGITS)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        cout_q      <= carry;
                    end else begin
                        a_q   <= a_q >> 4;
                        b_q   <= b_q >> 4;
                        s_q   <= s_next;
                        carry <= t_adj[4];
                        idx   <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.busy      = busy_q;
endmodule
